// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - shared types and screen defaults for the rasterizer pixel path
package raster_pkg;

    localparam int COORD_W  = 11;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic signed [COORD_W-1:0] coord_s;
    typedef logic        [COORD_W-1:0] coord_u;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Inclusive box corners, signed so off-screen primitives can be expressed
    typedef struct packed {
        coord_s min_x;
        coord_s min_y;
        coord_s max_x;
        coord_s max_y;
    } bbox_t;

endpackage

// File: rtl/bbox_clamp.sv
// rtl/bbox_clamp.sv - clamps a signed bounding box to the screen and flags empty results
module bbox_clamp #(
    parameter int SCREEN_W = raster_pkg::SCREEN_W,
    parameter int SCREEN_H = raster_pkg::SCREEN_H
) (
    input  raster_pkg::bbox_t i_box,
    output raster_pkg::bbox_t o_box,
    output logic              o_empty
);
    import raster_pkg::*;

    localparam coord_s C_ZERO = '0;
    localparam coord_s C_XMAX = coord_s'(SCREEN_W - 1);
    localparam coord_s C_YMAX = coord_s'(SCREEN_H - 1);

    // Pull each edge onto the screen; only the lower edges can go negative, only the upper edges can overflow
    always_comb begin
        o_box = i_box;
        if ($signed(i_box.min_x) < $signed(C_ZERO)) o_box.min_x = C_ZERO;
        if ($signed(i_box.min_y) < $signed(C_ZERO)) o_box.min_y = C_ZERO;
        if ($signed(i_box.max_x) > $signed(C_XMAX)) o_box.max_x = C_XMAX;
        if ($signed(i_box.max_y) > $signed(C_YMAX)) o_box.max_y = C_YMAX;
    end

    // Inverted boxes and boxes entirely off screen both collapse to min > max after clamping
    assign o_empty = ($signed(o_box.min_x) > $signed(o_box.max_x)) ||
                     ($signed(o_box.min_y) > $signed(o_box.max_y));

endmodule

// File: rtl/raster_pixel_scanner.sv
// rtl/raster_pixel_scanner.sv - walks a clamped bounding box in raster order onto a pixel stream
module raster_pixel_scanner #(
    parameter int COORD_W  = raster_pkg::COORD_W,
    parameter int SCREEN_W = raster_pkg::SCREEN_W,
    parameter int SCREEN_H = raster_pkg::SCREEN_H
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [COORD_W-1:0] min_x,
    input  logic signed [COORD_W-1:0] min_y,
    input  logic signed [COORD_W-1:0] max_x,
    input  logic signed [COORD_W-1:0] max_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [COORD_W-1:0] pixel_x,
    output logic        [COORD_W-1:0] pixel_y,
    output logic                      last,
    output logic                      done,
    output logic                      busy
);
    import raster_pkg::*;

    scan_state_t        r_state;
    scan_state_t        w_state_next;
    logic [COORD_W-1:0] r_pixel_x;
    logic [COORD_W-1:0] r_pixel_y;
    logic [COORD_W-1:0] r_cmin_x;
    logic [COORD_W-1:0] r_cmax_x;
    logic [COORD_W-1:0] r_cmax_y;
    logic               r_done;
    logic               r_ready_en;

    bbox_t w_cmd_box;
    bbox_t w_clamped;
    logic  w_empty;
    logic  w_accept;
    logic  w_fire;
    logic  w_x_at_max;
    logic  w_last;

    assign w_cmd_box = '{min_x: coord_s'(min_x), min_y: coord_s'(min_y),
                         max_x: coord_s'(max_x), max_y: coord_s'(max_y)};

    bbox_clamp #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clamp (
        .i_box   (w_cmd_box),
        .o_box   (w_clamped),
        .o_empty (w_empty)
    );

    assign w_accept   = cmd_valid & cmd_ready;
    assign w_fire     = out_valid & out_ready;
    assign w_x_at_max = (r_pixel_x == r_cmax_x);
    // Gated by SCAN so the all-zero reset registers never look like a final pixel
    assign w_last     = (r_state == SCAN) & w_x_at_max & (r_pixel_y == r_cmax_y);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: empty boxes never leave IDLE, a scan ends on the handshake of its last pixel
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_empty) w_state_next = SCAN;
            SCAN:    if (w_fire && w_last)     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Stream and handshake outputs decoded from state; cmd_ready waits one edge after reset
    always_comb begin
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE:    cmd_ready = r_ready_en;
            SCAN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    // Box latch, raster-order walk and done pulse; coordinates only move on a handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pixel_x  <= '0;
            r_pixel_y  <= '0;
            r_cmin_x   <= '0;
            r_cmax_x   <= '0;
            r_cmax_y   <= '0;
            r_done     <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_done     <= (w_accept & w_empty) | (w_fire & w_last);
            if (w_accept) begin
                r_cmin_x <= COORD_W'(w_clamped.min_x);
                r_cmax_x <= COORD_W'(w_clamped.max_x);
                r_cmax_y <= COORD_W'(w_clamped.max_y);
                if (!w_empty) begin
                    r_pixel_x <= COORD_W'(w_clamped.min_x);
                    r_pixel_y <= COORD_W'(w_clamped.min_y);
                end
            end else if (w_fire && !w_last) begin
                if (!w_x_at_max) begin
                    r_pixel_x <= r_pixel_x + COORD_W'(1);
                end else begin
                    r_pixel_x <= r_cmin_x;
                    r_pixel_y <= r_pixel_y + COORD_W'(1);
                end
            end
        end
    end

    assign pixel_x = r_pixel_x;
    assign pixel_y = r_pixel_y;
    assign last    = w_last;
    assign done    = r_done;

endmodule

// File: tb/tb_raster_pixel_scanner.sv
// tb/tb_raster_pixel_scanner.sv - scoreboard bench for the raster pixel scanner
module tb_raster_pixel_scanner;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [10:0] min_x, min_y, max_x, max_y;
    logic               out_valid;
    logic               out_ready;
    logic        [10:0] pixel_x, pixel_y;
    logic               last, done, busy;

    typedef struct {
        bit is_done;
        int x;
        int y;
        bit last;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;
    bit  prev_accept, prev_hs_last, prev_hs_nonlast;

    raster_pixel_scanner dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .min_x     (min_x),
        .min_y     (min_y),
        .max_x     (max_x),
        .max_y     (max_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .last      (last),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push_pix(input int x, input int y, input bit l);
        ev_t e;
        e.is_done = 1'b0; e.x = x; e.y = y; e.last = l;
        sb.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.is_done = 1'b1; e.x = 0; e.y = 0; e.last = 1'b0;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input int c, input int d);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_timeout", int'(n < 50), 1);
        cmd_valid = 1'b1;
        min_x = 11'(a); min_y = 11'(b); max_x = 11'(c); max_y = 11'(d);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", int'(n < 200), 1);
    endtask

    // Monitor: pops the scoreboard on each handshake or done pulse, and checks stall/bubble/done timing
    always @(negedge clk) begin
        ev_t e;
        bit  hs, cur_last;
        if (reset) begin
            prev_accept = 0; prev_hs_last = 0; prev_hs_nonlast = 0;
        end else begin
            if (prev_hs_nonlast) chk("no_bubble_valid", int'(out_valid), 1);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", int'(e.is_done), 1);
                    chk("done_timing", int'(prev_accept | prev_hs_last), 1);
                end
            end
            hs = out_valid & out_ready;
            cur_last = 1'b0;
            if (hs) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("pix_kind", int'(e.is_done), 0);
                    chk("pix_x", int'(pixel_x), e.x);
                    chk("pix_y", int'(pixel_y), e.y);
                    chk("pix_last", int'(last), int'(e.last));
                    cur_last = e.last;
                end
            end else if (out_valid && sb.size() > 0 && !sb[0].is_done) begin
                chk("stall_x", int'(pixel_x), sb[0].x);
                chk("stall_y", int'(pixel_y), sb[0].y);
                chk("stall_last", int'(last), int'(sb[0].last));
            end
            if (out_valid && !out_ready) prev_hs_nonlast = 1'b1;
            else prev_hs_nonlast = hs & ~cur_last;
            prev_hs_last = hs & cur_last;
            prev_accept  = cmd_valid & cmd_ready;
        end
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; out_ready = 1'b1;
        min_x = '0; min_y = '0; max_x = '0; max_y = '0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_pixel_x", int'(pixel_x), 0);
        chk("rst_pixel_y", int'(pixel_y), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rel_cmd_ready_low", int'(cmd_ready), 0);
        tick();
        chk("rel_cmd_ready_high", int'(cmd_ready), 1);

        // 1: plain 3x2 box at full throughput
        push_pix(2, 3, 0); push_pix(3, 3, 0); push_pix(4, 3, 0);
        push_pix(2, 4, 0); push_pix(3, 4, 0); push_pix(4, 4, 1);
        push_done();
        send(2, 3, 4, 4);
        chk("t1_first_valid", int'(out_valid), 1);
        chk("t1_first_x", int'(pixel_x), 2);
        chk("t1_first_y", int'(pixel_y), 3);
        chk("t1_busy", int'(busy), 1);
        chk("t1_cmd_ready", int'(cmd_ready), 0);
        drain();

        // 2: out_ready toggling
        push_pix(0, 0, 0); push_pix(1, 0, 0); push_pix(2, 0, 0);
        push_pix(0, 1, 0); push_pix(1, 1, 0); push_pix(2, 1, 1);
        push_done();
        out_ready = 1'b1;
        send(0, 0, 2, 1);
        for (int n = 0; n < 100 && sb.size() > 0; n++) begin
            tick();
            out_ready = ~out_ready;
        end
        chk("t2_drained", sb.size(), 0);
        out_ready = 1'b1;
        tick();

        // 3: negative corner clamps to the screen origin
        push_pix(0, 0, 0); push_pix(1, 0, 1);
        push_done();
        send(-5, -2, 1, 0);
        drain();

        // 4: inverted box, then box entirely right of the screen
        push_done();
        send(10, 0, 5, 3);
        chk("t4a_done", int'(done), 1);
        chk("t4a_cmd_ready", int'(cmd_ready), 1);
        chk("t4a_out_valid", int'(out_valid), 0);
        drain();
        chk("t4a_cmd_ready_after", int'(cmd_ready), 1);
        push_done();
        send(700, 0, 800, 5);
        chk("t4b_done", int'(done), 1);
        chk("t4b_cmd_ready", int'(cmd_ready), 1);
        chk("t4b_out_valid", int'(out_valid), 0);
        drain();

        // 5: single pixel, then a command accepted in the done cycle
        push_pix(7, 7, 1);
        push_done();
        push_pix(0, 0, 1);
        push_done();
        send(7, 7, 7, 7);
        chk("t5_first_last", int'(last), 1);
        tick();
        chk("t5_done_cycle_done", int'(done), 1);
        chk("t5_done_cycle_ready", int'(cmd_ready), 1);
        send(0, 0, 0, 0);
        chk("t5_b2b_valid", int'(out_valid), 1);
        chk("t5_b2b_x", int'(pixel_x), 0);
        chk("t5_b2b_last", int'(last), 1);
        drain();

        // 6: reset in the middle of a scan
        push_pix(0, 0, 0); push_pix(1, 0, 0); push_pix(2, 0, 0);
        out_ready = 1'b1;
        send(0, 0, 3, 3);
        tick(); tick(); tick();
        out_ready = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_cmd_ready", int'(cmd_ready), 0);
        chk("t6_sb_consumed", sb.size(), 0);
        tick(); tick();
        reset = 1'b0;
        out_ready = 1'b1;
        chk("t6_rel_cmd_ready_low", int'(cmd_ready), 0);
        tick();
        chk("t6_rel_cmd_ready_high", int'(cmd_ready), 1);
        chk("t6_no_done", int'(done), 0);
        push_pix(1, 1, 0); push_pix(1, 2, 1);
        push_done();
        send(1, 1, 1, 2);
        chk("t6_restart_x", int'(pixel_x), 1);
        chk("t6_restart_y", int'(pixel_y), 1);
        drain();

        tick(); tick(); tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
